// File: rtl/outerprodrc_ctrl_if.sv
// Tile-in and result-out valid/ready handshakes of the outerprodrc sequencer.
// master = tile producer / result consumer, slave = the sequencer.
interface outerprodrc_ctrl_if #(
    parameter int HIDDEN      = 4,
    parameter int ROWNUM      = 4,
    parameter int COLNUM      = 4,
    parameter int BITWIDTH    = 8,
    parameter int OUTBITWIDTH = 16
);
    logic                                  iValid;
    logic                                  oReady;
    logic [HIDDEN*ROWNUM*BITWIDTH-1:0]     iData0;
    logic [HIDDEN*COLNUM*BITWIDTH-1:0]     iData1;
    logic                                  oValid;
    logic                                  iReady;
    logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0]  oResult;

    modport master (
        output iValid, iData0, iData1, iReady,
        input  oReady, oValid, oResult
    );

    modport slave (
        input  iValid, iData0, iData1, iReady,
        output oReady, oValid, oResult
    );
endinterface

// File: rtl/outerprodrc_ctrl.sv
// Tile sequencer for the outerprodrc array: skid-buffered tile intake,
// one clear + 2^BITWIDTH enable window per tile, registered sum capture.
module outerprodrc_ctrl #(
    parameter int HIDDEN      = 4,
    parameter int ROWNUM      = 4,
    parameter int COLNUM      = 4,
    parameter int BITWIDTH    = 8,
    parameter int OUTBITWIDTH = 16,
    parameter int SUMLAT      = 1
) (
    input  logic                                 iClk,
    input  logic                                 iRstN,
    outerprodrc_ctrl_if.slave                    bus,
    output logic                                 oEn,
    output logic                                 oClr,
    output logic [HIDDEN*ROWNUM*BITWIDTH-1:0]    oData0,
    output logic [HIDDEN*COLNUM*BITWIDTH-1:0]    oData1,
    input  logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] iSum
);
    localparam int D0W    = HIDDEN*ROWNUM*BITWIDTH;
    localparam int D1W    = HIDDEN*COLNUM*BITWIDTH;
    localparam int RW     = ROWNUM*COLNUM*OUTBITWIDTH;
    localparam int CYCLES = 2**BITWIDTH;
    localparam int CW     = BITWIDTH + 1;
    localparam int WW     = (SUMLAT > 1) ? $clog2(SUMLAT) : 1;

    localparam logic [CW-1:0] CLAST = CW'(CYCLES - 1);
    localparam logic [WW-1:0] WLAST = WW'(SUMLAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic            buf_full_q;
    logic [D0W-1:0]  buf0_q, act0_q;
    logic [D1W-1:0]  buf1_q, act1_q;
    logic            vld_q;
    logic [RW-1:0]   res_q;

    logic take, load, cap, at_cap;

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            buf_full_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            act0_q     <= '0;
            act1_q     <= '0;
            vld_q      <= 1'b0;
            res_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            if (take) begin
                buf0_q     <= bus.iData0;
                buf1_q     <= bus.iData1;
                buf_full_q <= 1'b1;
            end else if (load) begin
                buf_full_q <= 1'b0;
            end
            if (load) begin
                act0_q <= buf0_q;
                act1_q <= buf1_q;
            end
            // A fresh capture wins over the consumer draining the old result
            if (cap) begin
                res_q <= iSum;
                vld_q <= 1'b1;
            end else if (bus.iReady) begin
                vld_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (buf_full_q) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_RUN: begin
                if (cnt_q == CLAST) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (wcnt_q != WLAST) begin
                    wcnt_d = wcnt_q + WW'(1);
                end else if (!vld_q || bus.iReady) begin
                    state_d = buf_full_q ? S_CLEAR : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        oEn    = (state_q == S_RUN);
        oClr   = (state_q == S_CLEAR);
        at_cap = (state_q == S_WAIT) && (wcnt_q == WLAST);
        cap    = at_cap && (!vld_q || bus.iReady);
        load   = buf_full_q && ((state_q == S_IDLE) || cap);
        take   = bus.iValid && !buf_full_q;
    end

    assign bus.oReady  = ~buf_full_q;
    assign bus.oValid  = vld_q;
    assign bus.oResult = res_q;
    assign oData0      = act0_q;
    assign oData1      = act1_q;
endmodule

// File: tb/tb_outerprodrc_ctrl.sv
// Bench for outerprodrc_ctrl: rate-coded array model, expected sums
// from the closed form sum_h min(a,b), directed timing with random tiles.
module tb_outerprodrc_ctrl;
    localparam int H   = 4;
    localparam int R   = 4;
    localparam int C   = 4;
    localparam int BW  = 8;
    localparam int OBW = 16;
    localparam int D0W = H*R*BW;
    localparam int D1W = H*C*BW;
    localparam int RW  = R*C*OBW;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    outerprodrc_ctrl_if #(.HIDDEN(H), .ROWNUM(R), .COLNUM(C),
        .BITWIDTH(BW), .OUTBITWIDTH(OBW)) b1 ();
    outerprodrc_ctrl_if #(.HIDDEN(H), .ROWNUM(R), .COLNUM(C),
        .BITWIDTH(BW), .OUTBITWIDTH(OBW)) b3 ();

    logic           en1, clr1, en3, clr3;
    logic [D0W-1:0] od0_1, od0_3;
    logic [D1W-1:0] od1_1, od1_3;
    logic [RW-1:0]  sum1, sum3;

    outerprodrc_ctrl #(.HIDDEN(H), .ROWNUM(R), .COLNUM(C), .BITWIDTH(BW),
        .OUTBITWIDTH(OBW), .SUMLAT(1)) u_dut (
        .iClk(clk), .iRstN(rstn), .bus(b1.slave),
        .oEn(en1), .oClr(clr1), .oData0(od0_1), .oData1(od1_1),
        .iSum(sum1));

    outerprodrc_ctrl #(.HIDDEN(H), .ROWNUM(R), .COLNUM(C), .BITWIDTH(BW),
        .OUTBITWIDTH(OBW), .SUMLAT(3)) u_dut3 (
        .iClk(clk), .iRstN(rstn), .bus(b3.slave),
        .oEn(en3), .oClr(clr3), .oData0(od0_3), .oData1(od1_3),
        .iSum(sum3));

    // One window cycle of a unary (rate-coded) array: bit streams a>t, b>t
    function automatic logic [RW-1:0] arr_step(input logic [RW-1:0] cur,
        input logic [D0W-1:0] a, input logic [D1W-1:0] b, input int t);
        logic [RW-1:0] nx;
        nx = cur;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                int inc;
                inc = 0;
                for (int h = 0; h < H; h++)
                    if (int'(a[(h*R+r)*BW +: BW]) > t &&
                        int'(b[(h*C+c)*BW +: BW]) > t) inc++;
                nx[(r*C+c)*OBW +: OBW] = cur[(r*C+c)*OBW +: OBW] + OBW'(inc);
            end
        end
        return nx;
    endfunction

    function automatic logic [RW-1:0] ref_sum(input logic [D0W-1:0] a,
        input logic [D1W-1:0] b);
        logic [RW-1:0] s;
        s = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                int acc;
                acc = 0;
                for (int h = 0; h < H; h++) begin
                    int x, y;
                    x = int'(a[(h*R+r)*BW +: BW]);
                    y = int'(b[(h*C+c)*BW +: BW]);
                    acc += (x < y) ? x : y;
                end
                s[(r*C+c)*OBW +: OBW] = OBW'(acc);
            end
        end
        return s;
    endfunction

    function automatic logic [D0W-1:0] rnd0();
        logic [D0W-1:0] v;
        for (int i = 0; i < D0W/BW; i++) v[i*BW +: BW] = BW'($urandom_range(0, 255));
        return v;
    endfunction

    function automatic logic [D1W-1:0] rnd1();
        logic [D1W-1:0] v;
        for (int i = 0; i < D1W/BW; i++) v[i*BW +: BW] = BW'($urandom_range(0, 255));
        return v;
    endfunction

    logic [RW-1:0] acc1, acc3, p1_3, p2_3;
    int t1 = 0;
    int t3 = 0;

    always @(posedge clk) begin
        if (clr1) begin
            acc1 <= '0;
            t1 <= 0;
        end else if (en1) begin
            acc1 <= arr_step(acc1, od0_1, od1_1, t1);
            t1 <= t1 + 1;
        end
        if (clr3) begin
            acc3 <= '0;
            t3 <= 0;
        end else if (en3) begin
            acc3 <= arr_step(acc3, od0_3, od1_3, t3);
            t3 <= t3 + 1;
        end
        p1_3 <= acc3;
        p2_3 <= p1_3;
    end

    assign sum1 = acc1;
    assign sum3 = p2_3;

    int            clr_q[$];
    int            enr_q[$];
    int            vr_q[$];
    int            vr3_q[$];
    logic [RW-1:0] res_q[$];
    logic [RW-1:0] res3_q[$];
    int            en_cnt = 0;
    int            both = 0;
    logic          en_p = 1'b0;
    logic          v_p = 1'b0;
    logic          v3_p = 1'b0;

    always @(negedge clk) begin
        if (clr1) clr_q.push_back(cyc);
        if (en1) en_cnt++;
        if (en1 && !en_p) enr_q.push_back(cyc);
        if (en1 && clr1) both++;
        if (en3 && clr3) both++;
        if (b1.oValid && !v_p) begin
            vr_q.push_back(cyc);
            res_q.push_back(b1.oResult);
        end
        if (b3.oValid && !v3_p) begin
            vr3_q.push_back(cyc);
            res3_q.push_back(b3.oResult);
        end
        en_p = en1;
        v_p  = b1.oValid;
        v3_p = b3.oValid;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [RW-1:0] obs,
        input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [D0W-1:0] a, input logic [D1W-1:0] b,
        output int tacc);
        logic hit;
        int   tc;
        b1.iValid = 1'b1;
        b1.iData0 = a;
        b1.iData1 = b;
        tacc = -1;
        for (int i = 0; i < 2000 && tacc < 0; i++) begin
            @(negedge clk);
            hit = b1.oReady;
            tc  = cyc;
            tick();
            if (hit) tacc = tc;
        end
        b1.iValid = 1'b0;
        chk("send_accepted", int'(tacc >= 0), 1);
    endtask

    task automatic wait_vr(input int n, output int ok);
        for (int i = 0; i < 2000 && vr_q.size() < n; i++) tick();
        ok = int'(vr_q.size() >= n);
    endtask

    initial begin
        logic [D0W-1:0] a [3];
        logic [D1W-1:0] b [3];
        logic [RW-1:0]  e [3];
        int t0, ta, ok, nc, ne, nv, ec, tv, low;

        rstn = 1'b0;
        b1.iValid = 1'b0; b1.iData0 = '0; b1.iData1 = '0; b1.iReady = 1'b1;
        b3.iValid = 1'b0; b3.iData0 = '0; b3.iData1 = '0; b3.iReady = 1'b1;
        repeat (3) tick();
        chk("rst_ready", int'(b1.oReady), 1);
        chk("rst_en", int'(en1), 0);
        chk("rst_clr", int'(clr1), 0);
        chk("rst_valid", int'(b1.oValid), 0);
        chkv("rst_data0", RW'(od0_1), '0);
        chkv("rst_result", b1.oResult, '0);
        rstn = 1'b1;

        // idle with no tiles offered
        nc = clr_q.size(); nv = vr_q.size(); ec = en_cnt; low = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!b1.oReady) low++;
        end
        chk("idle_en", en_cnt - ec, 0);
        chk("idle_clr", clr_q.size() - nc, 0);
        chk("idle_valid", vr_q.size() - nv, 0);
        chk("idle_ready_low", low, 0);

        // single tile latency and result
        a[0] = rnd0(); b[0] = rnd1(); e[0] = ref_sum(a[0], b[0]);
        nc = clr_q.size(); ne = enr_q.size(); nv = vr_q.size(); ec = en_cnt;
        t0 = cyc;
        send1(a[0], b[0], ta);
        chk("t1_accept", ta - t0, 0);
        chk("t1_ready_full", int'(b1.oReady), 0);
        tick();
        chk("t1_clr_now", int'(clr1), 1);
        chk("t1_ready_loaded", int'(b1.oReady), 1);
        wait_vr(nv + 1, ok);
        chk("t1_valid_seen", ok, 1);
        chk("t1_clr_count", clr_q.size() - nc, 1);
        chk("t1_clr_cycle", clr_q[nc] - t0, 2);
        chk("t1_en_rises", enr_q.size() - ne, 1);
        chk("t1_en_first", enr_q[ne] - t0, 3);
        chk("t1_en_len", en_cnt - ec, 256);
        chk("t1_valid_cycle", vr_q[nv] - t0, 260);
        chkv("t1_result", res_q[nv], e[0]);

        // three tiles back to back
        for (int k = 0; k < 3; k++) begin
            a[k] = rnd0(); b[k] = rnd1(); e[k] = ref_sum(a[k], b[k]);
        end
        nc = clr_q.size(); nv = vr_q.size();
        repeat (3) tick();
        t0 = cyc;
        send1(a[0], b[0], ta);
        chk("b2b_acc0", ta - t0, 0);
        send1(a[1], b[1], ta);
        chk("b2b_acc1", ta - t0, 2);
        chk("b2b_ready_full", int'(b1.oReady), 0);
        send1(a[2], b[2], ta);
        chk("b2b_acc2", ta - t0, 260);
        wait_vr(nv + 3, ok);
        chk("b2b_valid_seen", ok, 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b2b_clr%0d", k), clr_q[nc+k] - t0, 2 + 258*k);
            chk($sformatf("b2b_vld%0d", k), vr_q[nv+k] - t0, 260 + 258*k);
            chkv($sformatf("b2b_res%0d", k), res_q[nv+k], e[k]);
        end

        // result backpressure with a second tile queued
        repeat (5) tick();
        for (int k = 0; k < 2; k++) begin
            a[k] = rnd0(); b[k] = rnd1(); e[k] = ref_sum(a[k], b[k]);
        end
        b1.iReady = 1'b0;
        nc = clr_q.size(); nv = vr_q.size(); ec = en_cnt;
        t0 = cyc;
        send1(a[0], b[0], ta);
        send1(a[1], b[1], ta);
        chk("bp_acc1", ta - t0, 2);
        wait_vr(nv + 1, ok);
        chk("bp_valid_seen", ok, 1);
        tv = vr_q[nv];
        chk("bp_valid_cycle", tv - t0, 260);
        chkv("bp_res_a", res_q[nv], e[0]);
        while (cyc < tv + 300) tick();
        chk("bp_stall_en", int'(en1), 0);
        chk("bp_stall_valid", int'(b1.oValid), 1);
        chkv("bp_stall_hold", b1.oResult, e[0]);
        chk("bp_b_loaded", clr_q.size() - nc, 2);
        while (cyc < tv + 400) tick();
        chkv("bp_hold_end", b1.oResult, e[0]);
        b1.iReady = 1'b1;
        tick();
        chk("bp_valid_kept", int'(b1.oValid), 1);
        chkv("bp_res_b", b1.oResult, e[1]);
        tick();
        chk("bp_valid_drop", int'(b1.oValid), 0);
        chk("bp_en_len", en_cnt - ec, 512);

        // reset in the middle of RUN with a tile buffered
        repeat (5) tick();
        a[0] = rnd0(); b[0] = rnd1();
        a[1] = rnd0(); b[1] = rnd1();
        t0 = cyc;
        send1(a[0], b[0], ta);
        send1(a[1], b[1], ta);
        while (cyc < t0 + 103) tick();
        chk("mr_running", int'(en1), 1);
        nv = vr_q.size();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mr_en", int'(en1), 0);
        chk("mr_clr", int'(clr1), 0);
        chk("mr_valid", int'(b1.oValid), 0);
        chk("mr_ready", int'(b1.oReady), 1);
        chkv("mr_data0", RW'(od0_1), '0);
        chkv("mr_data1", RW'(od1_1), '0);
        chkv("mr_result", b1.oResult, '0);
        nc = clr_q.size();
        repeat (700) tick();
        chk("mr_no_valid", vr_q.size() - nv, 0);
        chk("mr_no_clr", clr_q.size() - nc, 0);

        // SUMLAT=3 instance with a settling sum pipeline
        a[2] = rnd0(); b[2] = rnd1(); e[2] = ref_sum(a[2], b[2]);
        t0 = cyc;
        chk("s3_ready", int'(b3.oReady), 1);
        b3.iValid = 1'b1;
        b3.iData0 = a[2];
        b3.iData1 = b[2];
        tick();
        b3.iValid = 1'b0;
        for (int i = 0; i < 1000 && vr3_q.size() < 1; i++) tick();
        chk("s3_valid_seen", int'(vr3_q.size() >= 1), 1);
        chk("s3_valid_cycle", vr3_q[0] - t0, 262);
        chkv("s3_result", res3_q[0], e[2]);

        chk("en_clr_overlap", both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
